// File: rtl/i2c_target.sv
// I2C target (slave): fixed 7-bit address, write bytes to ODATA, read bytes from IDATA.
// SCL/SDA are oversampled on CLK; SDA is driven open-drain only and SCL is never stretched.
module i2c_target #(
    parameter logic [6:0] ADDRESS     = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       NRST,
    input  logic       I2C_SCL,
    inout  wire        I2C_SDA,
    input  logic [7:0] IDATA,
    output logic [7:0] ODATA,
    output logic       ODRDY,
    output logic       IDREQ,
    output logic       O_RW,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_RX_DATA,
        S_RX_ACK,
        S_TX_DATA,
        S_TX_ACK,
        S_WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] shift_in;
    logic       oe_q, oe_d;
    logic [7:0] odata_q, odata_d;
    logic       odrdy_q, odrdy_d;
    logic       idreq_q, idreq_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;

    // History loaded with 1 so leaving reset with the bus idle produces no edges.
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments give every flop the value from before
            // this edge, which is what makes the synchroniser chain shift by one stage.
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], I2C_SCL};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], I2C_SDA};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & ~sda_prev_q & sda_s;
    assign shift_in  = {shift_q[6:0], sda_s};

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            shift_q <= 8'h00;
            oe_q    <= 1'b0;
            odata_q <= 8'h00;
            odrdy_q <= 1'b0;
            idreq_q <= 1'b0;
            rw_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            oe_q    <= oe_d;
            odata_q <= odata_d;
            odrdy_q <= odrdy_d;
            idreq_q <= idreq_d;
            rw_q    <= rw_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        oe_d    = oe_q;
        odata_d = odata_q;
        odrdy_d = 1'b0;
        idreq_d = 1'b0;
        rw_d    = rw_q;
        busy_d  = busy_q;

        if (start_det) begin
            state_d = S_ADDR;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = 3'd0;
        end else if (stop_det) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = 3'd0;
        end else begin
            unique case (state_q)
                S_ADDR: if (scl_rise) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (shift_in[7:1] == ADDRESS) begin
                            rw_d    = shift_in[0];
                            state_d = S_ADDR_ACK;
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end
                end
                // oe_q distinguishes the fall that starts the ACK from the one that ends it.
                S_ADDR_ACK: if (scl_fall) begin
                    if (!oe_q) begin
                        oe_d   = 1'b1;
                        busy_d = 1'b1;
                        if (rw_q) begin
                            shift_d = IDATA;
                            idreq_d = 1'b1;
                        end
                    end else if (!rw_q) begin
                        oe_d    = 1'b0;
                        state_d = S_RX_DATA;
                    end else begin
                        oe_d    = ~shift_q[7];
                        state_d = S_TX_DATA;
                    end
                end
                S_RX_DATA: if (scl_rise) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        odata_d = shift_in;
                        odrdy_d = 1'b1;
                        state_d = S_RX_ACK;
                    end
                end
                S_RX_ACK: if (scl_fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else begin
                        oe_d    = 1'b0;
                        state_d = S_RX_DATA;
                    end
                end
                // Counts falls: the 8th ends the last data bit and hands SDA back.
                S_TX_DATA: if (scl_fall) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        oe_d    = 1'b0;
                        state_d = S_TX_ACK;
                    end else begin
                        oe_d = ~shift_q[6];
                    end
                end
                S_TX_ACK: begin
                    if (scl_rise && sda_s) begin
                        busy_d  = 1'b0;
                        state_d = S_WAIT_STOP;
                    end else if (scl_fall) begin
                        shift_d = IDATA;
                        idreq_d = 1'b1;
                        oe_d    = ~IDATA[7];
                        state_d = S_TX_DATA;
                    end
                end
                S_IDLE, S_WAIT_STOP: oe_d = 1'b0;
                default: begin
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    assign I2C_SDA = oe_q ? 1'b0 : 1'bz;
    assign ODATA   = odata_q;
    assign ODRDY   = odrdy_q;
    assign IDREQ   = idreq_q;
    assign O_RW    = rw_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bus-master model drives transfers while a monitor
// scores ODRDY/IDREQ pulses against queues of expected bytes.
module tb_i2c_target;

    localparam logic [6:0] ADDR = 7'h42;
    localparam int         Q    = 8;   // CLK cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       scl = 1'b1;
    logic       sda_low = 1'b0;
    wire        sda_w;
    logic [7:0] idata = 8'hFF;
    logic [7:0] odata;
    logic       odrdy, idreq, o_rw, busy;

    assign sda_w = sda_low ? 1'b0 : 1'bz;
    pullup (sda_w);

    always #5 clk = ~clk;

    i2c_target #(.ADDRESS(ADDR), .SYNC_STAGES(2)) dut (
        .CLK    (clk),
        .NRST   (nrst),
        .I2C_SCL(scl),
        .I2C_SDA(sda_w),
        .IDATA  (idata),
        .ODATA  (odata),
        .ODRDY  (odrdy),
        .IDREQ  (idreq),
        .O_RW   (o_rw),
        .BUSY   (busy)
    );

    int         vectors = 0;
    int         miscompares = 0;
    int         drive_cnt = 0;
    int         rd_idx = 0;
    logic [7:0] exp_odata_q[$];
    logic [7:0] exp_idreq_q[$];
    logic [7:0] rd_bytes[$];
    logic [7:0] tx_bytes[$];
    logic [7:0] model_odata = 8'h00;
    logic       odrdy_prev = 1'b0;
    logic       idreq_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scores output pulses and serves the next read byte after each load.
    always @(negedge clk) begin
        if (nrst) begin
            if (!sda_low && sda_w === 1'b0) drive_cnt++;
            if (odrdy) begin
                check("odrdy_one_clk", {31'd0, odrdy_prev}, 32'd0);
                check("pulse_overlap", {31'd0, idreq}, 32'd0);
                check("odrdy_expected", {31'd0, exp_odata_q.size() > 0}, 32'd1);
                if (exp_odata_q.size() > 0) check("odata", {24'd0, odata}, {24'd0, exp_odata_q.pop_front()});
            end
            if (idreq) begin
                check("idreq_one_clk", {31'd0, idreq_prev}, 32'd0);
                check("idreq_expected", {31'd0, exp_idreq_q.size() > 0}, 32'd1);
                if (exp_idreq_q.size() > 0) check("idreq_load", {24'd0, idata}, {24'd0, exp_idreq_q.pop_front()});
                rd_idx++;
            end
        end
        odrdy_prev = odrdy;
        idreq_prev = idreq;
        idata = (rd_idx < rd_bytes.size()) ? rd_bytes[rd_idx] : 8'hFF;
    end

    task automatic qwait();
        repeat (Q) @(posedge clk);
    endtask

    // START or repeated START; leaves SCL low.
    task automatic i2c_start();
        sda_low = 1'b0; qwait();
        scl = 1'b1;     qwait();
        sda_low = 1'b1; qwait();
        scl = 1'b0;     qwait();
    endtask

    // STOP from SCL low; leaves the bus idle.
    task automatic i2c_stop();
        sda_low = 1'b1; qwait();
        scl = 1'b1;     qwait();
        sda_low = 1'b0; qwait();
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_low = ~b; qwait();
        scl = 1'b1;   qwait();
        #1 s = sda_w;
        qwait();
        scl = 1'b0;   qwait();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(~master_ack, s);
    endtask

    // One complete transfer using tx_bytes as payload; expectations come from the address rule.
    task automatic xfer(input logic [6:0] addr, input logic rw);
        logic       match;
        logic       ack;
        logic [7:0] got;
        int         n;
        match = (addr == ADDR);
        n = tx_bytes.size();
        if (match && rw) begin
            foreach (tx_bytes[k]) rd_bytes.push_back(tx_bytes[k]);
            exp_idreq_q.push_back(tx_bytes[0]);
        end
        i2c_start();
        write_byte({addr, rw}, ack);
        check("addr_ack", {31'd0, ack}, {31'd0, ~match});
        check("busy_after_addr", {31'd0, busy}, {31'd0, match});
        if (match) check("o_rw", {31'd0, o_rw}, {31'd0, rw});
        if (!rw) begin
            for (int k = 0; k < n; k++) begin
                if (match) begin
                    exp_odata_q.push_back(tx_bytes[k]);
                    model_odata = tx_bytes[k];
                end
                write_byte(tx_bytes[k], ack);
                check("data_ack", {31'd0, ack}, {31'd0, ~match});
            end
        end else if (match) begin
            for (int k = 0; k < n; k++) begin
                if (k < n - 1) exp_idreq_q.push_back(tx_bytes[k+1]);
                read_byte(k < n - 1, got);
                check("rd_data", {24'd0, got}, {24'd0, tx_bytes[k]});
            end
            check("busy_after_nack", {31'd0, busy}, 32'd0);
        end
        i2c_stop();
        check("busy_after_stop", {31'd0, busy}, 32'd0);
        check("odata_hold", {24'd0, odata}, {24'd0, model_odata});
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] got;
        int         d0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_odata", {24'd0, odata}, 32'd0);
        check("rst_flags", {28'd0, odrdy, idreq, o_rw, busy}, 32'd0);
        check("rst_sda", {31'd0, sda_w}, 32'd1);
        nrst = 1'b1;
        qwait();

        // Write with address match.
        tx_bytes = '{8'hA5};
        xfer(ADDR, 1'b0);

        // Address mismatch: target must never touch SDA.
        d0 = drive_cnt;
        tx_bytes = '{8'h11};
        xfer(7'h43, 1'b0);
        check("mismatch_no_drive", drive_cnt - d0, 32'd0);

        // Read two bytes, ACK then NACK.
        tx_bytes = '{8'h3C, 8'hC3};
        xfer(ADDR, 1'b1);

        // Repeated START after 4 data bits of a write, then a read.
        i2c_start();
        write_byte({ADDR, 1'b0}, ack);
        check("rs_addr_ack", {31'd0, ack}, 32'd0);
        for (int i = 0; i < 4; i++) clock_bit(1'($urandom), s);
        got = 8'($urandom);
        rd_bytes.push_back(got);
        exp_idreq_q.push_back(got);
        i2c_start();
        check("rs_busy_cleared", {31'd0, busy}, 32'd0);
        write_byte({ADDR, 1'b1}, ack);
        check("rs_read_ack", {31'd0, ack}, 32'd0);
        check("rs_o_rw", {31'd0, o_rw}, 32'd1);
        check("rs_busy", {31'd0, busy}, 32'd1);
        begin
            logic [7:0] exp_b;
            exp_b = got;
            read_byte(1'b0, got);
            check("rs_rd_data", {24'd0, got}, {24'd0, exp_b});
        end
        i2c_stop();
        check("rs_odata_hold", {24'd0, odata}, {24'd0, model_odata});

        // Reset while the target pulls SDA low in bit 3 of a read byte.
        rd_bytes.push_back(8'h00);
        exp_idreq_q.push_back(8'h00);
        i2c_start();
        write_byte({ADDR, 1'b1}, ack);
        check("rst5_addr_ack", {31'd0, ack}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            clock_bit(1'b1, s);
            check("rst5_bit", {31'd0, s}, 32'd0);
        end
        sda_low = 1'b0; qwait();
        scl = 1'b1;     qwait();
        #1 check("rst5_driving", {31'd0, sda_w}, 32'd0);
        @(negedge clk) nrst = 1'b0;
        @(negedge clk) nrst = 1'b1;
        model_odata = 8'h00;
        check("rst5_sda_released", {31'd0, sda_w}, 32'd1);
        check("rst5_odata", {24'd0, odata}, 32'd0);
        check("rst5_flags", {28'd0, odrdy, idreq, o_rw, busy}, 32'd0);
        d0 = drive_cnt;
        qwait();
        scl = 1'b0; qwait();
        for (int i = 0; i < 5; i++) clock_bit(1'b1, s);
        check("rst5_ignored", drive_cnt - d0, 32'd0);
        tx_bytes = '{8'h5A};
        xfer(ADDR, 1'b0);

        // STOP after 5 bits of the second data byte.
        i2c_start();
        write_byte({ADDR, 1'b0}, ack);
        check("stop6_addr_ack", {31'd0, ack}, 32'd0);
        exp_odata_q.push_back(8'h77);
        model_odata = 8'h77;
        write_byte(8'h77, ack);
        check("stop6_data_ack", {31'd0, ack}, 32'd0);
        for (int i = 0; i < 5; i++) clock_bit(1'($urandom), s);
        i2c_stop();
        check("stop6_busy", {31'd0, busy}, 32'd0);
        check("stop6_odata", {24'd0, odata}, 32'h77);

        // Randomized transfers.
        for (int t = 0; t < 16; t++) begin
            logic [6:0] a;
            int         nb;
            a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ADDR;
            nb = $urandom_range(1, 3);
            tx_bytes.delete();
            for (int k = 0; k < nb; k++) tx_bytes.push_back(8'($urandom));
            xfer(a, 1'($urandom));
        end

        repeat (20) @(posedge clk);
        check("odrdy_all_seen", exp_odata_q.size(), 32'd0);
        check("idreq_all_seen", exp_idreq_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
I2C responder (slave) for the far end of an I2C controller. It matches a fixed 7-bit address and receives write bytes onto a parallel output. For reads it serialises bytes from a parallel input. Bus pins are oversampled on CLK; the block never stretches SCL and only drives SDA open-drain (0 or Z).

Parameters:
ADDRESS, 7'h42, 7-bit target address compared against the first byte after START.
SYNC_STAGES, 2, flip-flop synchroniser depth on SCL and SDA (minimum 2).

Ports:
CLK  input  1  system clock; must run at least 16x the SCL frequency.
NRST  input  1  synchronous, active-low reset.
I2C_SCL  input  1  bus clock, sampled only.
I2C_SDA  inout  1  bus data; drives 1'b0 or 1'bz, never 1'b1.
IDATA  input  8  byte to transmit on reads; sampled at shift-register load.
ODATA  output  8  last byte received in a write transfer.
ODRDY  output  1  one-CLK pulse: ODATA updated.
IDREQ  output  1  one-CLK pulse: IDATA was just loaded; present the next byte before the next load.
O_RW  output  1  R/W bit of the current addressed transfer (1 = read).
BUSY  output  1  high from address ACK until STOP, repeated START or read NACK.

Behaviour:
- Reset (NRST=0 at a CLK edge):
  - state to S_IDLE, SDA released (Z) on that edge.
  - ODATA=0, ODRDY=0, IDREQ=0, O_RW=0, BUSY=0; bit counter and shift register cleared.
  - Synchroniser history is loaded with 1, so no false edges appear after reset.
  - Reset mid-transfer: the bus is ignored until the next START.
- Synchronised signals: scl_s and sda_s; edges are detected from the previous synchronised value.
- START: sda_s falls while scl_s=1.
- STOP: sda_s rises while scl_s=1.
- START and STOP override every state, including S_IDLE and S_WAIT_STOP.
- SCL rise: sample SDA. SCL fall: update SDA drive.
- Bit order: MSB first. Bit counter is 3 bits and wraps 7->0 after the 8th sample.
- States:
  - S_IDLE: SDA Z. START -> S_ADDR.
  - S_ADDR: shift 8 bits on SCL rises.
    - After the 8th rise: if byte[7:1]==ADDRESS, latch O_RW=byte[0] and go to S_ADDR_ACK; otherwise go to S_WAIT_STOP.
    - General call (0x00) is not matched.
  - S_ADDR_ACK:
    - On the next SCL fall: drive SDA=0 and set BUSY=1.
    - If O_RW=1, also load IDATA into the shift register and pulse IDREQ.
    - On the following SCL fall: if O_RW=0, release SDA -> S_RX_DATA; if O_RW=1, drive the shift MSB -> S_TX_DATA.
  - S_RX_DATA:
    - Shift 8 SCL rises.
    - On the 8th rise: ODATA<=shift value, ODRDY pulses on the next CLK -> S_RX_ACK.
  - S_RX_ACK: drive SDA=0 from the next SCL fall to the following SCL fall, then release -> S_RX_DATA. Data bytes are always ACKed.
  - S_TX_DATA:
    - On each SCL fall, drive SDA=0 if the current bit is 0, else Z.
    - After the 8th bit's SCL fall, release SDA -> S_TX_ACK.
  - S_TX_ACK: sample SDA on the SCL rise.
    - 0 (ACK): on the next SCL fall, load IDATA, pulse IDREQ, drive MSB -> S_TX_DATA.
    - 1 (NACK): BUSY=0 -> S_WAIT_STOP.
  - S_WAIT_STOP: SDA Z. STOP -> S_IDLE; START -> S_ADDR.
- Repeated START in any state:
  - SDA released, BUSY=0, bit counter cleared -> S_ADDR.
  - A partial byte is discarded, with no ODRDY.
- STOP in any state:
  - SDA released, BUSY=0 -> S_IDLE.
  - A partial byte is discarded.
- START/STOP detection takes priority over SCL-edge processing in the same CLK cycle.
- ODRDY and IDREQ are never high for more than one CLK and are never high in the same cycle.
- Latency: ODRDY is asserted SYNC_STAGES+1 CLK cycles after the 8th data SCL rise at the pin.

Test Plan:
1. Write, address matches: START, byte 0x84 (addr 0x42, W), 0xA5, STOP.
   - Required: SDA=0 during both 9th clocks.
   - ODATA=0xA5 with exactly one ODRDY pulse; O_RW=0.
   - BUSY high between address ACK and STOP, then 0.
2. Address mismatch: START, 0x86, 0x11, STOP.
   - Required: SDA never driven; no ODRDY or IDREQ; BUSY stays 0; state S_IDLE after STOP.
3. Read: START, 0x85, IDATA=0x3C; master ACKs, IDATA=0xC3; master NACKs, STOP.
   - Required: target bits 0,0,1,1,1,1,0,0 then 1,1,0,0,0,0,1,1.
   - Exactly 2 IDREQ pulses (a 3rd load only follows an ACK); after the NACK, SDA released and BUSY=0.
4. Repeated START after 4 data bits of a write, then 0x85.
   - Required: no ODRDY; address re-matched; O_RW=1; read proceeds with IDATA.
5. NRST low for 1 CLK while target drives SDA=0 in bit 3 of a read byte.
   - Required: SDA Z on the next edge; all outputs reset.
   - Remaining SCL clocks are ignored until a new START, after which a write transfer succeeds.
6. STOP after 5 bits of a data byte.
   - Required: S_IDLE, no ODRDY, ODATA keeps its previous value, BUSY=0.
